aes_sbox_sched: RTL and testbench

Scheduler that shares one combinational s_box instance between two AES-128 requesters: key expansion (SubWord, 4 bytes) and round datapath (SubBytes, 16 bytes). It accepts one request at a time, streams its bytes through the s_box at one byte per clock, and assembles the substituted result in a register. It returns the result with a one-cycle valid pulse. It sits between the key-expansion unit, the round unit and the single s_box in the AES core, replacing 20 parallel s_box copies with one.

---
 rtl/aes_pkg.sv | 23 ++
 rtl/s_box.sv | 28 ++
 rtl/aes_sbox_sched.sv | 129 ++++++++++++
 tb/tb_aes_sbox_sched.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types and constants used by the AES core blocks.
// Holds the scheduler FSM / owner enumerations and the per-request byte counts.
package aes_pkg;

  typedef logic [127:0] aes_state_t;
  typedef logic [31:0]  aes_word_t;
  typedef logic [7:0]   aes_byte_t;

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    DONE
  } sbox_sched_state_e;

  typedef enum logic {
    OWN_KS,
    OWN_SB
  } sbox_owner_e;

  localparam int AES_KS_BYTES = 4;
  localparam int AES_SB_BYTES = 16;

endpackage

// File: rtl/s_box.sv
// AES forward S-box: combinational 8-bit substitution, input a, output c.
module s_box (
  input  logic [7:0] a,
  output logic [7:0] c
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign c = SBOX[a];

endmodule

// File: rtl/aes_sbox_sched.sv
// Shares a single s_box between the key-expansion (SubWord) and round
// (SubBytes) requesters, one byte per clock, with a one-cycle response pulse.
// Optional build macro AES_SBOX_SCHED_RR_ARB_EN selects round-robin
// arbitration; without it KS has fixed priority over SB.
module aes_sbox_sched
  import aes_pkg::*;
#(
  parameter int KS_BYTES = AES_KS_BYTES,
  parameter int SB_BYTES = AES_SB_BYTES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ks_req_valid,
  output logic         ks_req_ready,
  input  logic [31:0]  ks_word,
  output logic         ks_rsp_valid,
  output logic [31:0]  ks_sub_word,
  input  logic         sb_req_valid,
  output logic         sb_req_ready,
  input  logic [127:0] sb_state,
  output logic         sb_rsp_valid,
  output logic [127:0] sb_sub_state,
  output logic         busy
);

  sbox_sched_state_e state_q, state_d;
  sbox_owner_e       owner_q;
  logic [3:0]        cnt_q;
  logic [3:0]        last_idx;
  aes_state_t        operand_q;
  aes_word_t         ks_res_q;
  aes_state_t        sb_res_q;
  aes_byte_t         sbox_a, sbox_c;
  logic              grant_ks;
  logic              idle_ok;
  logic              hs_ks, hs_sb;

  s_box u_s_box (
    .a (sbox_a),
    .c (sbox_c)
  );

`ifdef AES_SBOX_SCHED_RR_ARB_EN
  sbox_owner_e rr_last_q;

  // Round-robin grant: on a tie the requester not served last wins.
  always_comb begin
    grant_ks = 1'b1;
    if (ks_req_valid && sb_req_valid) grant_ks = (rr_last_q == OWN_SB);
    else if (sb_req_valid)            grant_ks = 1'b0;
  end

  // Remember who was served last; reset value lets KS win the first tie.
  always_ff @(posedge clk) begin
    if (rst)        rr_last_q <= OWN_SB;
    else if (hs_ks) rr_last_q <= OWN_KS;
    else if (hs_sb) rr_last_q <= OWN_SB;
  end
`else
  // Fixed priority grant: KS wins whenever it is requesting.
  always_comb begin
    grant_ks = ks_req_valid || !sb_req_valid;
  end
`endif

  assign idle_ok      = (state_q == IDLE) && !rst;
  assign ks_req_ready = idle_ok && grant_ks;
  assign sb_req_ready = idle_ok && !grant_ks;
  assign hs_ks        = ks_req_ready && ks_req_valid;
  assign hs_sb        = sb_req_ready && sb_req_valid;

  assign last_idx     = (owner_q == OWN_KS) ? 4'(KS_BYTES - 1) : 4'(SB_BYTES - 1);
  assign sbox_a       = (state_q == SUB) ? operand_q[{cnt_q, 3'b000} +: 8] : 8'h00;

  assign ks_rsp_valid = !rst && (state_q == DONE) && (owner_q == OWN_KS);
  assign sb_rsp_valid = !rst && (state_q == DONE) && (owner_q == OWN_SB);
  assign busy         = !rst && (state_q != IDLE);
  assign ks_sub_word  = ks_res_q;
  assign sb_sub_state = sb_res_q;

  // Next-state logic: accept in IDLE, stream N bytes in SUB, pulse in DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs_ks || hs_sb) state_d = SUB;
      SUB:     if (cnt_q == last_idx) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state: FSM, owner and byte counter (counter holds at N-1).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_KS;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      if (hs_ks) begin
        owner_q <= OWN_KS;
        cnt_q   <= 4'd0;
      end else if (hs_sb) begin
        owner_q <= OWN_SB;
        cnt_q   <= 4'd0;
      end else if ((state_q == SUB) && (cnt_q != last_idx)) begin
        cnt_q   <= cnt_q + 4'd1;
      end
    end
  end

  // Operand capture on handshake; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (hs_ks)      operand_q <= {96'd0, ks_word};
    else if (hs_sb) operand_q <= sb_state;
  end

  // Result assembly: one substituted byte per SUB cycle into the owner's register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ks_res_q <= '0;
      sb_res_q <= '0;
    end else if (state_q == SUB) begin
      if (owner_q == OWN_KS) ks_res_q[{cnt_q[1:0], 3'b000} +: 8] <= sbox_c;
      else                   sb_res_q[{cnt_q, 3'b000} +: 8]      <= sbox_c;
    end
  end

endmodule

// File: tb/tb_aes_sbox_sched.sv
// Self-checking bench for aes_sbox_sched: directed cases plus randomized
// requests, compared every cycle against a transaction-level model whose
// S-box is computed from GF(2^8) inversion and the AES affine map.
module tb_aes_sbox_sched;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ks_req_valid = 1'b0;
  logic         ks_req_ready;
  logic [31:0]  ks_word = '0;
  logic         ks_rsp_valid;
  logic [31:0]  ks_sub_word;
  logic         sb_req_valid = 1'b0;
  logic         sb_req_ready;
  logic [127:0] sb_state = '0;
  logic         sb_rsp_valid;
  logic [127:0] sb_sub_state;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  aes_sbox_sched dut (
    .clk          (clk),
    .rst          (rst),
    .ks_req_valid (ks_req_valid),
    .ks_req_ready (ks_req_ready),
    .ks_word      (ks_word),
    .ks_rsp_valid (ks_rsp_valid),
    .ks_sub_word  (ks_sub_word),
    .sb_req_valid (sb_req_valid),
    .sb_req_ready (sb_req_ready),
    .sb_state     (sb_state),
    .sb_rsp_valid (sb_rsp_valid),
    .sb_sub_state (sb_sub_state),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
    return (v << k) | (v >> (8 - k));
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_ref(input logic [127:0] v, input int n);
    logic [127:0] r = '0;
    for (int i = 0; i < n; i++) r[i*8 +: 8] = sbox_ref(v[i*8 +: 8]);
    return r;
  endfunction

  int           cyc = 0;
  int           m_free = 0;
  int           m_pulse = -1;
  bit           m_own_sb = 1'b0;
  bit           m_rr_last_sb = 1'b1;
  logic [127:0] m_pend = '0;
  logic [31:0]  m_ks = '0;
  logic [127:0] m_sb = '0;

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    bit idle, g_ks;
    if (rst) begin
      check("rst_ks_ready", 128'(ks_req_ready), 128'(0));
      check("rst_sb_ready", 128'(sb_req_ready), 128'(0));
      check("rst_busy",     128'(busy),         128'(0));
      check("rst_ks_rsp",   128'(ks_rsp_valid), 128'(0));
      check("rst_sb_rsp",   128'(sb_rsp_valid), 128'(0));
      m_free = cyc + 1; m_pulse = -1; m_ks = '0; m_sb = '0; m_rr_last_sb = 1'b1;
    end else begin
      idle = (cyc >= m_free);
      g_ks = ks_req_valid || !sb_req_valid;
`ifdef AES_SBOX_SCHED_RR_ARB_EN
      if (ks_req_valid && sb_req_valid) g_ks = m_rr_last_sb;
`endif
      check("busy", 128'(busy), 128'(!idle));
      check("ks_ready", 128'(ks_req_ready), 128'(idle && g_ks));
      check("sb_ready", 128'(sb_req_ready), 128'(idle && !g_ks));
      check("ks_rsp_valid", 128'(ks_rsp_valid), 128'((cyc == m_pulse) && !m_own_sb));
      check("sb_rsp_valid", 128'(sb_rsp_valid), 128'((cyc == m_pulse) && m_own_sb));
      if (cyc == m_pulse) begin
        if (m_own_sb) begin
          check("sb_sub_state", sb_sub_state, m_pend);
          m_sb = m_pend;
        end else begin
          check("ks_sub_word", 128'(ks_sub_word), 128'(m_pend[31:0]));
          m_ks = m_pend[31:0];
        end
      end
      if (idle) begin
        check("ks_hold", 128'(ks_sub_word), 128'(m_ks));
        check("sb_hold", sb_sub_state, m_sb);
        if (ks_req_valid && g_ks) begin
          m_pend = sub_ref({96'd0, ks_word}, 4);
          m_own_sb = 1'b0; m_rr_last_sb = 1'b0;
          m_pulse = cyc + 5; m_free = cyc + 6;
        end else if (sb_req_valid && !g_ks) begin
          m_pend = sub_ref(sb_state, 16);
          m_own_sb = 1'b1; m_rr_last_sb = 1'b1;
          m_pulse = cyc + 17; m_free = cyc + 18;
        end
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic ks_req(input logic [31:0] w, input int dly, input bit chg);
    bit done = 1'b0;
    bit got;
    step(dly);
    ks_word = w; ks_req_valid = 1'b1;
    for (int k = 0; k < 80 && !done; k++) begin
      #1 got = ks_req_ready;
      @(posedge clk); #2;
      if (got) done = 1'b1;
    end
    ks_req_valid = 1'b0;
    if (chg) ks_word = 32'hffffffff;
    if (!done) check("ks_handshake_timeout", 128'(0), 128'(1));
  endtask

  task automatic sb_req(input logic [127:0] s, input int dly);
    bit done = 1'b0;
    bit got;
    step(dly);
    sb_state = s; sb_req_valid = 1'b1;
    for (int k = 0; k < 80 && !done; k++) begin
      #1 got = sb_req_ready;
      @(posedge clk); #2;
      if (got) done = 1'b1;
    end
    sb_req_valid = 1'b0;
    sb_state = ~s;
    if (!done) check("sb_handshake_timeout", 128'(0), 128'(1));
  endtask

  initial begin
    step(3);
    rst = 1'b0;
    step(2);
    // directed vectors with known answers
    check("ref_sbox_cf4f3c09", sub_ref(128'hcf4f3c09, 4), 128'h8a84eb01);
    ks_req(32'hcf4f3c09, 0, 1'b0);
    step(8);
    sb_req(128'h0f0e0d0c0b0a09080706050403020100, 0);
    step(20);
    sb_req(128'd0, 0);
    step(20);
    // tie, repeated so round-robin shows its alternation
    repeat (2) begin
      fork
        ks_req(32'h00000000, 0, 1'b0);
        sb_req({16{8'hff}}, 0);
      join
      step(20);
    end
    // operand latched at handshake
    ks_req(32'h00000001, 0, 1'b1);
    step(8);
    // reset in the middle of a SubBytes request
    sb_req(128'h00112233445566778899aabbccddeeff, 0);
    step(7);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(3);
    // back-to-back KS requests
    ks_req(32'h01020304, 0, 1'b0);
    ks_req(32'hdeadbeef, 0, 1'b0);
    step(8);
    // randomized traffic
    for (int i = 0; i < 30; i++) begin
      fork
        if ($urandom_range(0, 3) != 0)
          ks_req($urandom, $urandom_range(0, 6), 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 3) != 0)
          sb_req({$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 6));
      join
    end
    step(25);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
